mem_arbiter_n: RTL and testbench

//  N-master memory-port arbiter; parametrised successor of the two-port mem_controller.

---
 rtl/mem_arbiter_n_pkg.sv | 20 ++
 rtl/mem_arbiter_n_if.sv | 38 +++
 rtl/mem_arbiter_n_rr_arbiter.sv | 38 +++
 rtl/mem_arbiter_n.sv | 132 +++++++++++++
 tb/tb_mem_arbiter_n.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_n_pkg.sv
// Shared types for the N-master memory arbiter: FSM states, response codes
// and the arbitration mode selector.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_t;

  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERR  = 1'b1;

endpackage

// File: rtl/mem_arbiter_n_if.sv
// Bus bundles for the arbiter: the AHB-lite-style request side shared by all
// masters, and the single memory port with its ready handshake.
interface mem_ahb_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64
);
  logic [NUM_MASTERS-1:0]        HTRANS;
  logic [NUM_MASTERS*ADDR_W-1:0] HADDR;
  logic [NUM_MASTERS-1:0]        HWRITE;
  logic [NUM_MASTERS*DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0]             HRDATA;
  logic [NUM_MASTERS-1:0]        HREADY;
  logic                          HRESP;
  logic [NUM_MASTERS-1:0]        stall;

  modport master (output HTRANS, HADDR, HWRITE, HWDATA,
                  input  HRDATA, HREADY, HRESP, stall);
  modport slave  (input  HTRANS, HADDR, HWRITE, HWDATA,
                  output HRDATA, HREADY, HRESP, stall);
endinterface

interface mem_apb_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              PSEL;
  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (output PSEL, PADDR, PWRITE, PWDATA,
                  input  PRDATA, PREADY);
  modport slave  (input  PSEL, PADDR, PWRITE, PWDATA,
                  output PRDATA, PREADY);
endinterface

// File: rtl/mem_arbiter_n_rr_arbiter.sv
// Combinational request picker: searches upward from the pointer (wrapping)
// in round-robin mode, or from index 0 in fixed-priority mode.
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  arb_mode_t              mode,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       idx
);

  logic found;
  int   start;
  int   cand;

  // First requester found from the start position wins; grant stays one-hot
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    start = (mode == ARB_FIXED) ? 0 : int'(ptr);
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = start + i;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-master memory-port arbiter: one access at a time through
// IDLE -> GRANT -> ACCESS -> RESP, with per-master completion pulse,
// registered read data and a bus-timeout error response.
module mem_arbiter_n
  import mem_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic     CLK,
  input  logic     reset_n,
  mem_ahb_if.slave ahb,
  mem_apb_if.master apb
);

  localparam int          IDX_W        = $clog2(NUM_MASTERS);
  localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  state_t                 state, state_next;
  arb_mode_t              mode;
  logic [NUM_MASTERS-1:0] win_grant;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       id_q;
  logic [ADDR_W-1:0]      sel_addr, paddr_q;
  logic [DATA_W-1:0]      sel_wdata, pwdata_q, hrdata_q;
  logic                   sel_write, pwrite_q, hresp_q;
  logic [31:0]            tcount;
  logic                   take_req, finish_ok, finish_err;
  logic [NUM_MASTERS-1:0] hready;

  assign mode = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

  rr_arbiter #(.NUM_MASTERS(NUM_MASTERS), .IDX_W(IDX_W)) u_arb (
    .req   (ahb.HTRANS),
    .mode  (mode),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx)
  );

  // Route the winning master's request fields using the one-hot grant
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (win_grant[i]) begin
        sel_addr  = ahb.HADDR[i*ADDR_W +: ADDR_W];
        sel_wdata = ahb.HWDATA[i*DATA_W +: DATA_W];
        sel_write = ahb.HWRITE[i];
      end
    end
  end

  // State register; reset aborts any access in flight without a completion
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state logic; PREADY only counts once the access phase is reached
  always_comb begin
    state_next = state;
    take_req   = 1'b0;
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|win_grant) begin
          take_req   = 1'b1;
          state_next = ST_GRANT;
        end
      end
      ST_GRANT: state_next = ST_ACCESS;
      ST_ACCESS: begin
        if (apb.PREADY) begin
          finish_ok  = 1'b1;
          state_next = ST_RESP;
        end else if (TIMEOUT != 0 && tcount == TIMEOUT_LAST) begin
          finish_err = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Latch the granted request, track access cycles and capture the response
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      id_q     <= '0;
      rr_ptr   <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      hresp_q  <= HRESP_OKAY;
      tcount   <= '0;
    end else begin
      if (take_req) begin
        id_q     <= win_idx;
        paddr_q  <= sel_addr;
        pwrite_q <= sel_write;
        pwdata_q <= sel_wdata;
        rr_ptr   <= (win_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : win_idx + IDX_W'(1);
      end
      if (state == ST_GRANT) tcount <= '0;
      else if (state == ST_ACCESS && !finish_ok && !finish_err) tcount <= tcount + 32'd1;
      if (finish_ok) begin
        hresp_q <= HRESP_OKAY;
        if (!pwrite_q) hrdata_q <= apb.PRDATA;
      end
      if (finish_err) hresp_q <= HRESP_ERR;
    end
  end

  assign hready     = (state == ST_RESP) ? (NUM_MASTERS'(1) << id_q) : '0;
  assign ahb.HREADY = hready;
  assign ahb.HRDATA = hrdata_q;
  assign ahb.HRESP  = hresp_q;
  assign ahb.stall  = ahb.HTRANS & ~hready;
  assign apb.PSEL   = (state == ST_GRANT) || (state == ST_ACCESS);
  assign apb.PADDR  = paddr_q;
  assign apb.PWRITE = pwrite_q;
  assign apb.PWDATA = pwdata_q;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n: a round-robin instance checked every cycle against a
// transaction-timeline model, plus a fixed-priority instance and directed cases.
module tb_mem_arbiter_n;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 8;

  logic CLK = 1'b0;
  logic reset_n = 1'b0;

  always #5 CLK = ~CLK;

  mem_ahb_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) ahb ();
  mem_apb_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();
  mem_ahb_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) ahb_fx ();
  mem_apb_if #(.ADDR_W(AW), .DATA_W(DW)) apb_fx ();

  mem_arbiter_n #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT(TO)) dut (
    .CLK(CLK), .reset_n(reset_n), .ahb(ahb), .apb(apb));

  mem_arbiter_n #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT(TO)) dut_fx (
    .CLK(CLK), .reset_n(reset_n), .ahb(ahb_fx), .apb(apb_fx));

  int compared = 0;
  int mismatched = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction granted in cycle g keeps PSEL from g+1 until
  // its done cycle d (PREADY seen at >= g+2, or g+1+TO), pulses HREADY at d+1,
  // and the arbiter can grant again at d+2.
  int          n = 0;
  bit          active = 0;
  int          g_cyc, d_cyc, m_id;
  logic [63:0] m_addr, m_wdata, m_hrdata;
  logic        m_write, m_resp;
  int          m_ptr = 0;
  logic [N-1:0] last_ready = '0;

  always @(negedge CLK) begin : compare_proc
    logic       exp_psel;
    logic [N-1:0] exp_ready;
    int         c;
    last_ready = ahb.HREADY;
    if (!reset_n) begin
      check_output("rst_psel", apb.PSEL, 0);
      check_output("rst_hready", ahb.HREADY, 0);
      check_output("rst_hresp", ahb.HRESP, 0);
      check_output("rst_paddr", apb.PADDR, 0);
      check_output("rst_pwrite", apb.PWRITE, 0);
      check_output("rst_pwdata", apb.PWDATA, 0);
      check_output("rst_hrdata", ahb.HRDATA, 0);
      active   = 0;
      m_ptr    = 0;
      m_hrdata = '0;
    end else begin
      exp_psel  = 1'b0;
      exp_ready = '0;
      if (active && (d_cyc < 0 || n <= d_cyc)) exp_psel = 1'b1;
      else if (active && n == d_cyc + 1) exp_ready[m_id] = 1'b1;
      check_output("psel", apb.PSEL, exp_psel);
      check_output("hready", ahb.HREADY, exp_ready);
      check_output("stall", ahb.stall, ahb.HTRANS & ~exp_ready);
      check_output("hrdata", ahb.HRDATA, m_hrdata);
      if (exp_psel) begin
        check_output("paddr", apb.PADDR, m_addr);
        check_output("pwrite", apb.PWRITE, m_write);
        check_output("pwdata", apb.PWDATA, m_wdata);
      end
      if (|exp_ready) check_output("hresp", ahb.HRESP, m_resp);
      if (!active) begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (!active && ahb.HTRANS[c]) begin
            active  = 1;
            m_id    = c;
            g_cyc   = n;
            d_cyc   = -1;
            m_addr  = ahb.HADDR[c*AW +: AW];
            m_write = ahb.HWRITE[c];
            m_wdata = ahb.HWDATA[c*DW +: DW];
            m_ptr   = (c + 1) % N;
          end
        end
      end else if (exp_psel) begin
        if (n >= g_cyc + 2) begin
          if (apb.PREADY) begin
            d_cyc  = n;
            m_resp = 1'b0;
            if (!m_write) m_hrdata = apb.PRDATA;
          end else if (n == g_cyc + 1 + TO) begin
            d_cyc  = n;
            m_resp = 1'b1;
          end
        end
      end else if (n == d_cyc + 1) begin
        active = 0;
      end
    end
    n++;
  end

  logic [N-1:0] req_on = '0;
  int           quiet = 0;

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Random masters that hold requests until served, and a memory with random latency
  task automatic apply_stimulus();
    for (int i = 0; i < N; i++) begin
      if (req_on[i] && last_ready[i]) req_on[i] = 1'b0;
      if (!req_on[i] && $urandom_range(0, 3) == 0) begin
        req_on[i] = 1'b1;
        ahb.HADDR[i*AW +: AW]  = {$urandom, $urandom};
        ahb.HWRITE[i]          = 1'($urandom_range(0, 1));
        ahb.HWDATA[i*DW +: DW] = {$urandom, $urandom};
      end
      ahb.HTRANS[i] = req_on[i];
    end
    if (quiet > 0) begin
      apb.PREADY = 1'b0;
      quiet--;
    end else begin
      apb.PREADY = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) quiet = 10;
    end
    apb.PRDATA = {$urandom, $urandom};
  endtask

  task automatic drain();
    ahb.HTRANS = '0;
    apb.PREADY = 1'b0;
    req_on     = '0;
    repeat (14) next_cycle();
  endtask

  int got[5];
  int cnt;
  int m0_cnt;

  initial begin
    ahb.HTRANS = '0; ahb.HADDR = '0; ahb.HWRITE = '0; ahb.HWDATA = '0;
    apb.PRDATA = '0; apb.PREADY = 1'b0;
    ahb_fx.HTRANS = '0; ahb_fx.HADDR = '0; ahb_fx.HWRITE = '0; ahb_fx.HWDATA = '0;
    apb_fx.PRDATA = 64'h77; apb_fx.PREADY = 1'b1;

    repeat (2) next_cycle();
    check_output("init_psel", apb.PSEL, 0);
    check_output("init_hready", ahb.HREADY, 0);
    reset_n = 1'b1;
    repeat (3) next_cycle();

    // Round-robin fairness: everyone requests continuously, memory always ready
    ahb.HTRANS = 4'b1111;
    for (int i = 0; i < N; i++) ahb.HADDR[i*AW +: AW] = 64'h100 * (i + 1);
    apb.PREADY = 1'b1;
    for (int k = 0; k < 5; k++) got[k] = -1;
    cnt = 0;
    repeat (20) begin
      @(negedge CLK);
      if (ahb.HREADY != '0 && cnt < 5) begin
        for (int k = 0; k < N; k++) if (ahb.HREADY[k]) got[cnt] = k;
        cnt++;
      end
      next_cycle();
    end
    ahb.HTRANS = '0;
    apb.PREADY = 1'b0;
    check_output("rr_order0", got[0], 0);
    check_output("rr_order1", got[1], 1);
    check_output("rr_order2", got[2], 2);
    check_output("rr_order3", got[3], 3);
    check_output("rr_order4", got[4], 0);
    repeat (4) next_cycle();

    // Single read by master 0, memory ready on the second access cycle
    ahb.HTRANS = 4'b0001;
    ahb.HADDR[0 +: AW] = 64'h1000;
    ahb.HWRITE = '0;
    next_cycle();
    @(negedge CLK);
    check_output("rd_psel", apb.PSEL, 1);
    check_output("rd_paddr", apb.PADDR, 64'h1000);
    next_cycle();
    next_cycle();
    apb.PREADY = 1'b1;
    apb.PRDATA = 64'hDEAD;
    next_cycle();
    apb.PREADY = 1'b0;
    @(negedge CLK);
    check_output("rd_hready", ahb.HREADY, 4'b0001);
    check_output("rd_hrdata", ahb.HRDATA, 64'hDEAD);
    check_output("rd_hresp", ahb.HRESP, 0);
    next_cycle();
    ahb.HTRANS = '0;
    repeat (3) next_cycle();

    // Write by master 1; read data register must not change
    ahb.HTRANS = 4'b0010;
    ahb.HADDR[AW +: AW] = 64'h20;
    ahb.HWRITE = 4'b0010;
    ahb.HWDATA[DW +: DW] = 64'hCAFE;
    apb.PRDATA = 64'h5555;
    next_cycle();
    @(negedge CLK);
    check_output("wr_paddr", apb.PADDR, 64'h20);
    check_output("wr_pwrite", apb.PWRITE, 1);
    check_output("wr_pwdata", apb.PWDATA, 64'hCAFE);
    next_cycle();
    apb.PREADY = 1'b1;
    next_cycle();
    apb.PREADY = 1'b0;
    @(negedge CLK);
    check_output("wr_hready", ahb.HREADY, 4'b0010);
    check_output("wr_hrdata", ahb.HRDATA, 64'hDEAD);
    next_cycle();
    ahb.HTRANS = '0;
    ahb.HWRITE = '0;
    repeat (3) next_cycle();

    // Timeout: master 3 reads, memory never ready
    ahb.HTRANS = 4'b1000;
    ahb.HADDR[3*AW +: AW] = 64'h3000;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      @(negedge CLK);
      if (c < 10) check_output("to_wait", ahb.HREADY, 0);
    end
    check_output("to_hready", ahb.HREADY, 4'b1000);
    check_output("to_hresp", ahb.HRESP, 1);
    check_output("to_hrdata", ahb.HRDATA, 64'hDEAD);
    next_cycle();
    ahb.HTRANS = '0;
    repeat (3) next_cycle();

    // Fixed priority instance: masters 0 and 2 request continuously
    ahb_fx.HTRANS = 4'b0101;
    ahb_fx.HADDR[0 +: AW] = 64'hA0;
    ahb_fx.HADDR[2*AW +: AW] = 64'hA2;
    m0_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      check_output("fx_hready2", ahb_fx.HREADY[2], 0);
      check_output("fx_stall2", ahb_fx.stall[2], 1);
      if (ahb_fx.HREADY[0]) m0_cnt++;
      next_cycle();
    end
    check_output("fx_m0_count", m0_cnt, 10);
    ahb_fx.HTRANS = '0;

    // Randomized traffic
    req_on = '0;
    repeat (2000) begin
      apply_stimulus();
      next_cycle();
    end
    drain();

    // Reset in the middle of an access
    ahb.HTRANS = 4'b0100;
    ahb.HADDR[2*AW +: AW] = 64'h2222;
    ahb.HWRITE = '0;
    repeat (3) next_cycle();
    #1;
    reset_n = 1'b0;
    #1;
    check_output("midrst_psel", apb.PSEL, 0);
    check_output("midrst_hready", ahb.HREADY, 0);
    ahb.HTRANS = '0;
    repeat (2) next_cycle();
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      check_output("postrst_hready", ahb.HREADY, 0);
      next_cycle();
    end
    ahb.HTRANS = 4'b0010;
    ahb.HADDR[AW +: AW] = 64'h44;
    next_cycle();
    @(negedge CLK);
    check_output("postrst_grant", apb.PSEL, 1);
    next_cycle();
    apb.PREADY = 1'b1;
    next_cycle();
    apb.PREADY = 1'b0;
    next_cycle();
    ahb.HTRANS = '0;

    req_on = '0;
    repeat (1000) begin
      apply_stimulus();
      next_cycle();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
